wbm: RTL

WBM -- requirements
Module: wbm

---
 rtl/wbm_if.sv | 33 +++
 rtl/wbm.sv | 123 ++++++++++++
 2 files changed

// File: rtl/wbm_if.sv
// Write-back / decode bus of the WBM stage: commit handshake, two read ports
// and the destination-register reservation channel.
interface wbm_if;
    logic        input_valid_i;
    logic        input_ready_o;
    logic        reg_write_i;
    logic [4:0]  reg_addr_i;
    logic [31:0] reg_data_i;
    logic [4:0]  raddr1_i;
    logic [4:0]  raddr2_i;
    logic [31:0] rdata1_o;
    logic [31:0] rdata2_o;
    logic        rbusy1_o;
    logic        rbusy2_o;
    logic        reserve_i;
    logic [4:0]  reserve_addr_i;
    logic        reserve_ready_o;
    logic        err_o;

    modport slave (
        input  input_valid_i, reg_write_i, reg_addr_i, reg_data_i,
        input  raddr1_i, raddr2_i, reserve_i, reserve_addr_i,
        output input_ready_o, rdata1_o, rdata2_o, rbusy1_o, rbusy2_o,
        output reserve_ready_o, err_o
    );

    modport master (
        output input_valid_i, reg_write_i, reg_addr_i, reg_data_i,
        output raddr1_i, raddr2_i, reserve_i, reserve_addr_i,
        input  input_ready_o, rdata1_o, rdata2_o, rbusy1_o, rbusy2_o,
        input  reserve_ready_o, err_o
    );
endinterface

// File: rtl/wbm.sv
// Write-back stage: 32x32 register file with a 2-bit pending-write scoreboard.
// Optional macro WBM_BYPASS_EN forwards a same-cycle commit to the read ports.
module wbm (
    input  logic   clk_i,
    input  logic   rst_i,
    wbm_if.slave   bus
);

    logic [31:1][31:0] regs_q;
    logic [31:1][31:0] regs_d;
    logic [31:1][1:0]  cnt_q;
    logic [31:1][1:0]  cnt_d;
    logic              err_q;
    logic              err_d;

    logic              commit_fire;
    logic              write_fire;
    logic              reserve_fire;
    logic [31:1]       commit_hit;
    logic [31:1]       reserve_hit;
    logic [31:1]       write_hit;
    logic [31:1]       underflow;
    logic [1:0]        reserve_cnt;

    // Index 0 is never stored, so every lookup of x0 yields zero.
    function automatic logic [31:0] pick_data(input logic [4:0] a,
                                              input logic [31:1][31:0] r);
        logic [31:0] v;
        v = '0;
        for (int i = 1; i < 32; i++) begin
            if (a == 5'(i)) v = r[i];
        end
        return v;
    endfunction

    function automatic logic [1:0] pick_cnt(input logic [4:0] a,
                                            input logic [31:1][1:0] c);
        logic [1:0] v;
        v = '0;
        for (int i = 1; i < 32; i++) begin
            if (a == 5'(i)) v = c[i];
        end
        return v;
    endfunction

    assign bus.input_ready_o = ~rst_i;
    assign commit_fire       = bus.input_valid_i & ~rst_i;
    assign write_fire        = commit_fire & bus.reg_write_i;

    always_comb begin
        reserve_cnt         = pick_cnt(bus.reserve_addr_i, cnt_q);
        bus.reserve_ready_o = ~rst_i &
                              ((bus.reserve_addr_i == 5'd0) || (reserve_cnt != 2'd3));
    end

    assign reserve_fire = bus.reserve_i & bus.reserve_ready_o;

    genvar gi;
    generate
        for (gi = 1; gi < 32; gi++) begin : g_reg
            assign commit_hit[gi]  = commit_fire  && (bus.reg_addr_i == 5'(gi));
            assign reserve_hit[gi] = reserve_fire && (bus.reserve_addr_i == 5'(gi));
            assign write_hit[gi]   = commit_hit[gi] & bus.reg_write_i;
            // A reservation landing together with its commit cancels out, so only
            // a lone commit on an idle counter is an underflow.
            assign underflow[gi]   = commit_hit[gi] & ~reserve_hit[gi] & (cnt_q[gi] == 2'd0);

            assign regs_d[gi] = write_hit[gi] ? bus.reg_data_i : regs_q[gi];

            assign cnt_d[gi] =
                (reserve_hit[gi] && !commit_hit[gi] && (cnt_q[gi] != 2'd3)) ? cnt_q[gi] + 2'd1 :
                (commit_hit[gi] && !reserve_hit[gi] && (cnt_q[gi] != 2'd0)) ? cnt_q[gi] - 2'd1 :
                cnt_q[gi];
        end
    endgenerate

    assign err_d = err_q | (|underflow);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            regs_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            regs_q <= regs_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    assign bus.err_o = err_q;

    always_comb begin
        bus.rdata1_o = pick_data(bus.raddr1_i, regs_q);
        bus.rbusy1_o = |pick_cnt(bus.raddr1_i, cnt_q);
`ifdef WBM_BYPASS_EN
        if (write_fire && (bus.reg_addr_i != 5'd0) && (bus.raddr1_i == bus.reg_addr_i)) begin
            bus.rdata1_o = bus.reg_data_i;
            bus.rbusy1_o = |pick_cnt(bus.raddr1_i, cnt_d);
        end
`endif
        if (rst_i) begin
            bus.rdata1_o = '0;
            bus.rbusy1_o = 1'b0;
        end
    end

    always_comb begin
        bus.rdata2_o = pick_data(bus.raddr2_i, regs_q);
        bus.rbusy2_o = |pick_cnt(bus.raddr2_i, cnt_q);
`ifdef WBM_BYPASS_EN
        if (write_fire && (bus.reg_addr_i != 5'd0) && (bus.raddr2_i == bus.reg_addr_i)) begin
            bus.rdata2_o = bus.reg_data_i;
            bus.rbusy2_o = |pick_cnt(bus.raddr2_i, cnt_d);
        end
`endif
        if (rst_i) begin
            bus.rdata2_o = '0;
            bus.rbusy2_o = 1'b0;
        end
    end

endmodule
